odd_parity_rx: RTL and testbench

- Serial frame receiver that sits directly upstream of the odd-parity checker.
- Recovers one asynchronous serial frame from a single line: start bit, DATA_W data bits (LSB first), one odd-parity bit, and one stop bit.
- Presents the data word with a registered parity verdict and a one-cycle valid strobe for the consumer stage.
- Parity is computed on the fly while bits shift in, so the verdict is ready in the same cycle as the data.

---
 rtl/odd_parity_rx.sv | 162 ++++++++++++++++
 tb/tb_odd_parity_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/odd_parity_rx.sv
// Asynchronous serial frame receiver: start, DATA_W data bits (LSB first),
// odd-parity bit, stop bit. Parity is accumulated while the bits shift in.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low (start edge)
// START     | confirming start bit at its mid-point, glitch rejection
// DATA      | sampling DATA_W data bits mid-bit, shifting and accumulating
// PARITY    | sampling the parity bit into the accumulator
// STOP      | sampling the stop bit, registering the result and valid
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module odd_parity_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_ok,
  output logic              frame_err,
  output logic              valid,
  output logic              busy
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                acc_q, acc_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                parity_ok_q, parity_ok_d;
  logic                frame_err_q, frame_err_d;
  logic                valid_q, valid_d;
  logic                rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], rx_in};
    state_d     = state_q;
    tick_d      = tick_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    data_d      = data_q;
    parity_ok_d = parity_ok_q;
    frame_err_d = frame_err_q;
    valid_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (!rx_s) begin
          state_d   = S_START;
          acc_d     = 1'b0;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick_q == TICK_HALF) begin
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_q == TICK_LAST) begin
          // Shift right with the new bit entering at the MSB, so the first
          // received bit lands in bit 0 once all DATA_W bits are in.
          for (int i = 0; i < DATA_W - 1; i++) begin
            shift_d[i] = shift_q[i+1];
          end
          shift_d[DATA_W-1] = rx_s;
          acc_d     = acc_q ^ rx_s;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          tick_d    = '0;
          if (bit_cnt_q == CNT_LAST) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (tick_q == TICK_LAST) begin
          acc_d   = acc_q ^ rx_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_q == TICK_LAST) begin
          data_d      = shift_q;
          parity_ok_d = acc_q;
          frame_err_d = ~rx_s;
          valid_d     = 1'b1;
          state_d     = rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        tick_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      tick_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      acc_q       <= 1'b0;
      data_q      <= '0;
      parity_ok_q <= 1'b0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      data_q      <= data_d;
      parity_ok_q <= parity_ok_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign parity_ok = parity_ok_q;
  assign frame_err = frame_err_q;
  assign valid     = valid_q;
  // The valid cycle itself counts as busy even though the FSM is back in IDLE.
  assign busy      = (state_q != S_IDLE) || valid_q;

endmodule

// File: tb/tb_odd_parity_rx.sv
// Bench for odd_parity_rx: directed frames plus random frames checked against
// a frame-level model (expected word, parity verdict, framing error, timing).
module tb_odd_parity_rx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          parity_ok;
  logic          frame_err;
  logic          valid;
  logic          busy;

  odd_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .parity_ok (parity_ok),
    .frame_err (frame_err),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          pok;
    logic          ferr;
  } exp_t;

  exp_t          exp_q[$];
  int            vcyc_q[$];
  exp_t          e_m;
  logic [DW-1:0] last_d = '0;
  logic          last_pok = 1'b0;
  logic          last_ferr = 1'b0;
  int            t_start = 0;

  // Every valid pulse must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e_m = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(e_m.d));
        chk("parity_ok", 32'(parity_ok), 32'(e_m.pok));
        chk("frame_err", 32'(frame_err), 32'(e_m.ferr));
        chk("busy_in_valid", 32'(busy), 1);
        last_d    = e_m.d;
        last_pok  = e_m.pok;
        last_ferr = e_m.ferr;
      end
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Caller is always positioned at a negedge; line is left at the stop value.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
    logic [DW+2:0] fr;
    exp_t e;
    e.d    = d;
    e.pok  = (($countones(d) + int'(p)) % 2) == 1;
    e.ferr = !s;
    exp_q.push_back(e);
    fr = {s, p, d, 1'b0};
    t_start = cyc;
    for (int i = 0; i < DW + 3; i++) begin
      rx_in = fr[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_data"}, 32'(data_out), 32'(last_d));
    chk({tag, "_pok"}, 32'(parity_ok), 32'(last_pok));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(last_ferr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          rp, rs;
    logic [DW-1:0] abort_d;

    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_pok", 32'(parity_ok), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(4);

    // Basic odd-parity frame plus latency measurement
    vcyc_q.delete();
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(2 * CPB);
    chk("a5_count", 32'(vcyc_q.size()), 1);
    if (vcyc_q.size() > 0) begin
      chk("a5_latency", 32'((vcyc_q[0] - t_start >= 44) && (vcyc_q[0] - t_start <= 46)), 1);
    end
    chk("a5_busy_after", 32'(busy), 0);

    // Even total ones -> parity fails
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    chk("07_pok_out", 32'(parity_ok), 0);

    // One-clock glitch in IDLE
    vcyc_q.delete();
    rx_in = 1'b0;
    @(negedge clk);
    idle(3 * CPB);
    chk("glitch_count", 32'(vcyc_q.size()), 0);
    chk("glitch_busy", 32'(busy), 0);
    check_held("glitch");

    // Stop bit 0 followed by a held-low line
    vcyc_q.delete();
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    chk("break_count", 32'(vcyc_q.size()), 1);
    chk("break_busy", 32'(busy), 1);
    chk("break_ferr_out", 32'(frame_err), 1);
    idle(2 * CPB);
    chk("break_busy_after", 32'(busy), 0);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(2 * CPB);
    chk("after_break_count", 32'(vcyc_q.size()), 2);

    // Reset during the 4th data bit
    vcyc_q.delete();
    abort_d = 8'h5A;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = abort_d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = abort_d[3];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_data", 32'(data_out), 0);
    chk("abort_pok", 32'(parity_ok), 0);
    chk("abort_ferr", 32'(frame_err), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_busy", 32'(busy), 0);
    last_d = '0;
    last_pok = 1'b0;
    last_ferr = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3 * CPB);
    chk("abort_count", 32'(vcyc_q.size()), 0);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(2 * CPB);
    chk("ff_count", 32'(vcyc_q.size()), 1);

    // Back-to-back frames with no idle gap
    vcyc_q.delete();
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b1);
    idle(2 * CPB);
    chk("b2b_count", 32'(vcyc_q.size()), 2);
    if (vcyc_q.size() == 2) begin
      chk("b2b_spacing", 32'(vcyc_q[1] - vcyc_q[0]), 32'((DW + 3) * CPB));
    end

    // Random frames, including occasional framing errors
    for (int n = 0; n < 24; n++) begin
      rd = DW'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rd, rp, rs);
      idle(2 * CPB + int'($urandom_range(0, 5)));
    end
    check_held("rand_hold");

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
